mdio_master: RTL and testbench
==============================

# mdio_master

Clause-22 MDIO management master for the Ethernet MAC; issues single read/write frames to the external PHY over MDC/MDIO. Sits in the management path alongside `ethernet_mac`. Its first user is a link-speed poller that reads PHY status registers, replacing clock-edge speed estimation. Runs in the 125 MHz system domain; MDIO tri-state buffer is at top level.

## Interface
- `CLK_DIV`, default 25: MDC half-period in `clk` cycles; must be ≥ 2. Default gives 2.5 MHz MDC at 125 MHz.
- `clk` input, 1 bit: system clock. One clock; reset is synchronous and active-high.
- `reset` input, 1 bit: synchronous, active-high reset.
- `cmd_valid` input, 1 bit: command request.
- `cmd_rdy` output, 1 bit: block idle, command accepted when `cmd_valid && cmd_rdy`.
- `cmd_write` input, 1 bit: 1 = write (OP 01), 0 = read (OP 10).
- `cmd_phy_addr` input, 5 bits: PHYAD.
- `cmd_reg_addr` input, 5 bits: REGAD.
- `cmd_wr_data` input, 16 bits: write payload.
- `rsp_valid` output, 1 bit: one-cycle pulse at frame end (reads and writes).
- `rsp_rd_data` output, 16 bits: read data; holds until the next read completes.
- `rsp_err` output, 1 bit: valid with `rsp_valid`; read saw no PHY turnaround zero.
- `mdc` output, 1 bit: management clock.
- `mdio_o` output, 1 bit: MDIO output value.
- `mdio_oe` output, 1 bit: MDIO output enable.
- `mdio_i` input, 1 bit: MDIO pad input, already synchronised at top level.

## Operation
- Frame, 64 bits MSB-first: PRE 32×'1', ST '01', OP, PHYAD[4:0], REGAD[4:0], TA, DATA[15:0].
- States:
  - IDLE: `cmd_rdy`=1; command fields are latched on accept; go to PRE.
  - PRE (32 bits) → HDR (14 bits: ST, OP, PHYAD, REGAD) → TA (2 bits) → DATA (16 bits) → DONE (1 cycle, `rsp_valid`) → IDLE.
- Bit counter is 6 bits and counts down per state. Zero means last bit of the state.
- Write frames: `mdio_oe`=1 for the whole frame. TA drives '10'; DATA drives `cmd_wr_data`.
- Read frames: `mdio_oe` drops to 0 at the start of TA and stays 0 through DATA.
  - Sample `mdio_i` on the MDC rising edge of TA bit 2; if it reads 1, set the error flag.
  - Shift `mdio_i` into the data register on each DATA rising edge.
  - `rsp_rd_data` updates at DONE only. It updates even on error, where the value is don't-care.
- `rsp_err` is always 0 for writes.
- `cmd_valid` while busy is ignored. No queuing; the requester holds `cmd_valid`.

## Timing
- Divider counter is $clog2(CLK_DIV) bits and wraps at CLK_DIV-1. It produces one-cycle `fall` and `rise` strobes.
- Bit period is 2×CLK_DIV cycles. MDC is low for the first CLK_DIV cycles and high for the next CLK_DIV.
- `mdio_o`/`mdio_oe` change only on the cycle MDC goes low (setup ≥ CLK_DIV cycles to the rising edge). `mdio_i` is sampled on the cycle MDC goes high.
- Accept at cycle T: first preamble bit drives at T+1 with `mdc`=0. `rsp_valid` is asserted at T+1+128×CLK_DIV; `cmd_rdy` returns at the following cycle.
- Back-to-back: the earliest next accept is the cycle after `rsp_valid`.
- Idle: `mdc`=0, `mdio_oe`=0, `mdio_o`=1.
- Reset values: `cmd_rdy`=0 (1 from the first cycle after reset), `rsp_valid`=0, `rsp_err`=0, `rsp_rd_data`=16'h0000, `mdc`=0, `mdio_o`=1, `mdio_oe`=0.
- Reset mid-frame: abort immediately. Outputs take reset values on the next cycle; no `rsp_valid` is produced.
- `reset` during the DONE cycle suppresses the pulse.

## Structure
- `mdio_pkg`:
  - opcode constants OP_WR=2'b01, OP_RD=2'b10, ST=2'b01;
  - PRE_BITS=32, HDR_BITS=14, TA_BITS=2, DATA_BITS=16;
  - the `mdio_state_t` enum (IDLE, PRE, HDR, TA, DATA, DONE).
- Sub-module `mdio_clk_gen`: parameter CLK_DIV; inputs `clk`, `reset`, `en`; outputs `mdc`, `rise`, `fall`. Held low and reset-aligned when `en`=0 so every frame starts on a fresh low phase.
- Top-level FSM, shift registers and bit counter stay in `mdio_master`.

## Test plan
(All with CLK_DIV=4; frame is 512 cycles.)
- Write PHY 5'h01, reg 5'h00, data 16'h1140:
  - the bench MDIO model decodes 32 ones, then 01 01 00001 00000 10 0001000101000000;
  - `mdio_oe` is high throughout;
  - `rsp_valid` pulses 513 cycles after accept with `rsp_err`=0.
- Read PHY 5'h01, reg 5'h11:
  - the model drives TA '0' then 16'hA5C3;
  - `mdio_oe` falls at the TA start;
  - `rsp_rd_data`=16'hA5C3 and `rsp_err`=0 at `rsp_valid`.
- Read with no PHY (pull-up, `mdio_i`=1) → `rsp_err`=1 and `rsp_valid` at cycle +513.
- `cmd_valid` held for two commands back-to-back:
  - the second accept comes exactly 1 cycle after the first `rsp_valid`;
  - `cmd_valid` pulses while busy are ignored (exactly 2 frames observed).
- Assert `reset` for 1 cycle at bit 40 of a read:
  - the next cycle has `mdc`=0, `mdio_oe`=0, `mdio_o`=1;
  - no `rsp_valid`;
  - `cmd_rdy`=1 one cycle after reset deasserts.
- Checker: throughout all tests, `mdio_o`/`mdio_oe` never change while `mdc`=1 and the MDC period is always 8 cycles.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared frame constants and FSM state encoding for the Clause-22 MDIO master.
package mdio_pkg;

    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] ST    = 2'b01;

    localparam int PRE_BITS  = 32;
    localparam int HDR_BITS  = 14;
    localparam int TA_BITS   = 2;
    localparam int DATA_BITS = 16;

    localparam int CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HDR,
        TA,
        DATA,
        DONE
    } mdio_state_t;

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: low phase then high phase of CLK_DIV cycles each, with one-cycle
// strobes on the cycle before each MDC edge. Parked low and phase-reset while disabled.
module mdio_clk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic mdc,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] WRAP = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          wrap;

    assign wrap = en && (div_cnt == WRAP);
    assign rise = wrap && !mdc;
    assign fall = wrap && mdc;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            div_cnt <= '0;
            mdc     <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            mdc     <= ~mdc;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one read or write frame per accepted command, result
// reported with a single-cycle rsp_valid pulse.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_rdy,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wr_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_rd_data,
    output logic        rsp_err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    mdio_state_t      state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             mdio_o_d, mdio_oe_d;
    logic             accept, last_bit, clk_en, rise, fall;
    logic             wr_q, err_q;
    logic [13:0]      hdr_sr;
    logic [15:0]      tx_sr, rx_sr;

    assign cmd_rdy   = (state_q == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_rdy;
    assign last_bit  = (bit_cnt_q == '0);
    assign clk_en    = (state_q == PRE) || (state_q == HDR) || (state_q == TA) || (state_q == DATA);
    assign rsp_valid = (state_q == DONE) && !reset;
    assign rsp_err   = rsp_valid && err_q;

    mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk   (clk),
        .reset (reset),
        .en    (clk_en),
        .mdc   (mdc),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            mdio_o    <= 1'b1;
            mdio_oe   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            mdio_o    <= mdio_o_d;
            mdio_oe   <= mdio_oe_d;
        end
    end

    // Every bit starts on an MDC fall strobe; outputs are chosen for the bit being entered.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        mdio_o_d  = mdio_o;
        mdio_oe_d = mdio_oe;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = PRE;
                    bit_cnt_d = CNT_W'(PRE_BITS - 1);
                    mdio_o_d  = 1'b1;
                    mdio_oe_d = 1'b1;
                end
            end
            PRE, HDR, TA, DATA: begin
                if (fall) begin
                    if (!last_bit) begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end else begin
                        case (state_q)
                            PRE:     begin state_d = HDR;  bit_cnt_d = CNT_W'(HDR_BITS - 1);  end
                            HDR:     begin state_d = TA;   bit_cnt_d = CNT_W'(TA_BITS - 1);   end
                            TA:      begin state_d = DATA; bit_cnt_d = CNT_W'(DATA_BITS - 1); end
                            default: begin state_d = DONE; bit_cnt_d = '0;                    end
                        endcase
                    end

                    case (state_d)
                        PRE:  mdio_o_d = 1'b1;
                        HDR:  mdio_o_d = hdr_sr[13];
                        TA: begin
                            mdio_o_d  = wr_q ? (bit_cnt_d != '0) : 1'b1;
                            mdio_oe_d = wr_q;
                        end
                        DATA: mdio_o_d = wr_q ? tx_sr[15] : 1'b1;
                        default: begin
                            mdio_o_d  = 1'b1;
                            mdio_oe_d = 1'b0;
                        end
                    endcase
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q   <= cmd_write;
            hdr_sr <= {ST, (cmd_write ? OP_WR : OP_RD), cmd_phy_addr, cmd_reg_addr};
            tx_sr  <= cmd_wr_data;
        end else if (fall) begin
            if (state_d == HDR)  hdr_sr <= {hdr_sr[12:0], 1'b0};
            if (state_d == DATA) tx_sr  <= {tx_sr[14:0], 1'b0};
        end
        if (rise && (state_q == DATA)) begin
            rx_sr <= {rx_sr[14:0], mdio_i};
        end
    end

    // A PHY that answers pulls the second turnaround bit low; a floating bus reads 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q       <= 1'b0;
            rsp_rd_data <= 16'h0000;
        end else begin
            if (accept) begin
                err_q <= 1'b0;
            end else if (rise && (state_q == TA) && last_bit && !wr_q) begin
                err_q <= mdio_i;
            end
            if ((state_q == DATA) && (state_d == DONE) && !wr_q) begin
                rsp_rd_data <= rx_sr;
            end
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master with CLK_DIV=4: frame decode, PHY read model,
// error reporting, back-to-back commands, mid-frame reset and MDC timing.
module tb_mdio_master;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_rdy;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wr_data;
    logic        rsp_valid;
    logic [15:0] rsp_rd_data;
    logic        rsp_err;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;

    always #5 clk = ~clk;

    mdio_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_rdy      (cmd_rdy),
        .cmd_write    (cmd_write),
        .cmd_phy_addr (cmd_phy_addr),
        .cmd_reg_addr (cmd_reg_addr),
        .cmd_wr_data  (cmd_wr_data),
        .rsp_valid    (rsp_valid),
        .rsp_rd_data  (rsp_rd_data),
        .rsp_err      (rsp_err),
        .mdc          (mdc),
        .mdio_o       (mdio_o),
        .mdio_oe      (mdio_oe),
        .mdio_i       (mdio_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor state
    int          acc_count = 0, acc_cyc = 0, acc_gap = 0;
    int          rsp_count = 0, rsp_cyc = 0, rsp_lat = 0;
    logic        rsp_err_s = 1'b0;
    logic [15:0] rsp_data_s = '0;
    int          cap_cnt = 0, last_rise = 0, oe_fall_off = -1;
    logic [63:0] cap_bits = '0, cap_oe = '0;
    int          viol = 0, per_viol = 0;
    logic        prev_mdc = 1'b0, prev_o = 1'b1, prev_oe = 1'b0;

    // PHY model: drives TA bit 2 low and then the response word, MSB first
    logic        phy_present = 1'b0;
    logic [16:0] phy_resp = '0;
    logic [4:0]  phy_idx;
    assign phy_idx = 5'(63 - cap_cnt);
    assign mdio_i  = (phy_present && cap_cnt >= 47 && cap_cnt <= 63) ? phy_resp[phy_idx] : 1'b1;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1 && cmd_rdy === 1'b1) begin
            acc_count   = acc_count + 1;
            acc_gap     = cyc - rsp_cyc;
            acc_cyc     = cyc;
            cap_cnt     = 0;
            cap_bits    = '0;
            cap_oe      = '0;
            oe_fall_off = -1;
        end
        if (mdc === 1'b1 && prev_mdc === 1'b0) begin
            if (cap_cnt > 0 && (cyc - last_rise) != 2 * CLK_DIV) per_viol = per_viol + 1;
            last_rise = cyc;
            cap_bits  = {cap_bits[62:0], mdio_o};
            cap_oe    = {cap_oe[62:0], mdio_oe};
            cap_cnt   = cap_cnt + 1;
        end
        if (mdc === 1'b1 && (mdio_o !== prev_o || mdio_oe !== prev_oe)) viol = viol + 1;
        if (prev_oe === 1'b1 && mdio_oe === 1'b0 && oe_fall_off < 0) oe_fall_off = cyc - acc_cyc;
        if (rsp_valid === 1'b1) begin
            rsp_count  = rsp_count + 1;
            rsp_cyc    = cyc;
            rsp_lat    = cyc - acc_cyc;
            rsp_err_s  = rsp_err;
            rsp_data_s = rsp_rd_data;
        end
        prev_mdc = mdc;
        prev_o   = mdio_o;
        prev_oe  = mdio_oe;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_acc(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (acc_count >= target) break;
        end
        check("accept_seen", 64'(acc_count >= target), 64'd1);
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (rsp_count >= target) break;
        end
        check("rsp_seen", 64'(rsp_count >= target), 64'd1);
    endtask

    task automatic send(input logic wr, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
        int base;
        base         = acc_count;
        cmd_write    = wr;
        cmd_phy_addr = pa;
        cmd_reg_addr = ra;
        cmd_wr_data  = wd;
        cmd_valid    = 1'b1;
        wait_acc(base + 1, 100);
        cmd_valid    = 1'b0;
    endtask

    initial begin
        int base_a, base_r;
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_phy_addr = '0;
        cmd_reg_addr = '0;
        cmd_wr_data  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_rdy",   64'(cmd_rdy),     64'd0);
        check("rst_rsp_valid", 64'(rsp_valid),   64'd0);
        check("rst_rsp_err",   64'(rsp_err),     64'd0);
        check("rst_rd_data",   64'(rsp_rd_data), 64'h0);
        check("rst_mdc",       64'(mdc),         64'd0);
        check("rst_mdio_o",    64'(mdio_o),      64'd1);
        check("rst_mdio_oe",   64'(mdio_oe),     64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", 64'(cmd_rdy), 64'd1);

        // Write PHY 1, reg 0, 0x1140
        @(posedge clk); #1;
        send(1'b1, 5'h01, 5'h00, 16'h1140);
        wait_rsp(1, 1000);
        check("wr_bits",    cap_bits, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h1140});
        check("wr_nbits",   64'(cap_cnt), 64'd64);
        check("wr_oe",      cap_oe, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wr_oe_fall", 64'(oe_fall_off), 64'd513);
        check("wr_lat",     64'(rsp_lat), 64'd513);
        check("wr_err",     64'(rsp_err_s), 64'd0);
        check("wr_pulse",   64'(rsp_valid), 64'd0);
        check("wr_rdy",     64'(cmd_rdy), 64'd1);
        check("wr_rd_hold", 64'(rsp_rd_data), 64'h0);

        // Read with nobody on the bus
        phy_present = 1'b0;
        send(1'b0, 5'h07, 5'h01, 16'h0000);
        wait_rsp(2, 1000);
        check("nophy_err", 64'(rsp_err_s), 64'd1);
        check("nophy_lat", 64'(rsp_lat), 64'd513);

        // Read PHY 1, reg 0x11, PHY returns 0xA5C3
        phy_present = 1'b1;
        phy_resp    = {1'b0, 16'hA5C3};
        send(1'b0, 5'h01, 5'h11, 16'h0000);
        wait_rsp(3, 1000);
        check("rd_hdr",     64'(cap_bits[63:18]), 64'({32'hFFFF_FFFF, 2'b01, 2'b10, 5'h01, 5'h11}));
        check("rd_oe",      cap_oe, {{46{1'b1}}, 18'h0});
        check("rd_oe_fall", 64'(oe_fall_off), 64'd369);
        check("rd_data",    64'(rsp_data_s), 64'hA5C3);
        check("rd_err",     64'(rsp_err_s), 64'd0);
        check("rd_lat",     64'(rsp_lat), 64'd513);
        phy_present = 1'b0;

        // Back-to-back writes with cmd_valid held and wiggled while busy
        base_a       = acc_count;
        base_r       = rsp_count;
        cmd_write    = 1'b1;
        cmd_phy_addr = 5'h02;
        cmd_reg_addr = 5'h04;
        cmd_wr_data  = 16'hBEEF;
        cmd_valid    = 1'b1;
        wait_acc(base_a + 1, 100);
        cmd_phy_addr = 5'h03;
        cmd_reg_addr = 5'h1F;
        cmd_wr_data  = 16'h0F0F;
        for (int k = 0; k < 4; k++) begin
            cmd_valid = 1'b0;
            repeat (10) @(posedge clk);
            #1 cmd_valid = 1'b1;
            repeat (10) @(posedge clk);
            #1;
        end
        wait_acc(base_a + 2, 1000);
        cmd_valid = 1'b0;
        check("b2b_gap", 64'(acc_gap), 64'd1);
        wait_rsp(base_r + 2, 1000);
        check("b2b_bits", cap_bits, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h03, 5'h1F, 2'b10, 16'h0F0F});
        repeat (600) @(posedge clk);
        #1;
        check("b2b_accepts", 64'(acc_count - base_a), 64'd2);
        check("b2b_frames",  64'(rsp_count - base_r), 64'd2);
        check("rd_data_hold", 64'(rsp_rd_data), 64'hA5C3);

        // Reset pulse in the middle of a read
        base_r      = rsp_count;
        phy_present = 1'b1;
        send(1'b0, 5'h01, 5'h01, 16'h0000);
        for (int i = 0; i < 1000; i++) begin
            if (cap_cnt >= 40) break;
            @(posedge clk); #1;
        end
        check("abort_reached_bit40", 64'(cap_cnt >= 40), 64'd1);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_mdc",     64'(mdc),       64'd0);
        check("abort_mdio_oe", 64'(mdio_oe),   64'd0);
        check("abort_mdio_o",  64'(mdio_o),    64'd1);
        check("abort_rdy",     64'(cmd_rdy),   64'd1);
        check("abort_rsp",     64'(rsp_valid), 64'd0);
        repeat (600) @(posedge clk);
        #1;
        check("abort_no_rsp", 64'(rsp_count - base_r), 64'd0);
        phy_present = 1'b0;

        check("mdio_stable_while_mdc_high", 64'(viol), 64'd0);
        check("mdc_period", 64'(per_viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
